fnd_multi_ch_scanner: RTL and testbench

FND_MULTI_CH_SCANNER -- requirements
Module: fnd_multi_ch_scanner

---
 rtl/fnd_pkg.sv | 16 +
 rtl/fnd_seg_decoder.sv | 18 +
 rtl/fnd_multi_ch_scanner.sv | 132 +++++++++++++
 tb/tb_fnd_multi_ch_scanner.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// fnd_pkg: shared constants for the FND scanner.
//   NUM_DIGITS  - digits on the display (4)
//   SEG_BLANK   - all segments off (active-low)
//   SEG_CODES   - active-low {dp,g..a} codes for 0..9, dp off
//   sat99()     - clamp a byte to 0..99 for two-digit display
package fnd_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [9:0][7:0] SEG_CODES = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [6:0] sat99(input logic [7:0] b);
    return (b > 8'd99) ? 7'd99 : b[6:0];
  endfunction
endpackage

// File: rtl/fnd_seg_decoder.sv
// fnd_seg_decoder: combinational 7-segment decoder.
//   val   - digit value 0..9 (others decode to blank)
//   blank - force all segments off
//   dp    - 1 lights the decimal point
//   seg   - active-low {dp,g..a}
module fnd_seg_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] val,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    if (!blank && (val < 4'd10)) seg = {~dp, SEG_CODES[val][6:0]};
  end
endmodule

// File: rtl/fnd_multi_ch_scanner.sv
// fnd_multi_ch_scanner: 4-digit multiplexed FND driver showing one of
// NUM_CH sensor channels as "II.DD", manual or auto-rotating selection.
//   clk, rst      - clock, async active-high reset
//   ch_int/ch_dec - packed per-channel bytes, channel k at [8k+7:8k]
//   mode_auto     - 1 = rotate channels every ROT_SEC seconds
//   ch_sel        - manual channel (out of range selects 0)
//   fnd_data      - active-low segments {dp,g..a}
//   fnd_com       - active-low digit enables, bit 0 = rightmost
//   cur_ch        - channel of the frame being displayed
// Optional macro FND_LZB_EN: blank the leading integer digit when zero.
module fnd_multi_ch_scanner
  import fnd_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000,
  parameter int NUM_CH  = 4,
  parameter int ROT_SEC = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH*8-1:0]       ch_int,
  input  logic [NUM_CH*8-1:0]       ch_dec,
  input  logic                      mode_auto,
  input  logic [$clog2(NUM_CH)-1:0] ch_sel,
  output logic [7:0]                fnd_data,
  output logic [3:0]                fnd_com,
  output logic [$clog2(NUM_CH)-1:0] cur_ch
);
  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SEC_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int ROT_W    = (ROT_SEC > 1) ? $clog2(ROT_SEC) : 1;
  localparam int CH_W     = $clog2(NUM_CH);

  logic [DIV_W-1:0] div_cnt;
  logic [SEC_W-1:0] sec_cnt;
  logic [ROT_W-1:0] rot_sec_cnt;
  logic [CH_W-1:0]  rot_idx, rot_nxt, sel_ch;
  logic [1:0]       idx;
  logic [6:0]       snap_int, snap_dec;
  logic [7:0]       sel_int, sel_dec, seg;
  logic [3:0]       dig_val;
  logic             scan_tick, frame_end, sec_tick, rot_adv, blank, dp;

  assign scan_tick = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign frame_end = scan_tick && (idx == 2'(NUM_DIGITS - 1));
  assign sec_tick  = mode_auto && (sec_cnt == SEC_W'(CLK_HZ - 1));
  assign rot_adv   = sec_tick && (rot_sec_cnt == ROT_W'(ROT_SEC - 1));

  // Selection looks at the rotation index as it will be after this edge,
  // so an advance landing exactly on a frame boundary is shown at once.
  always_comb begin
    rot_nxt = rot_idx;
    if (!mode_auto) rot_nxt = '0;
    else if (rot_adv) rot_nxt = (rot_idx == CH_W'(NUM_CH - 1)) ? '0 : rot_idx + 1'b1;
    if (mode_auto)                 sel_ch = rot_nxt;
    else if (int'(ch_sel) < NUM_CH) sel_ch = ch_sel;
    else                           sel_ch = '0;
  end

  assign sel_int = ch_int[{sel_ch, 3'b000} +: 8];
  assign sel_dec = ch_dec[{sel_ch, 3'b000} +: 8];

  always_comb begin
    dig_val = '0;
    unique case (idx)
      2'd0: dig_val = 4'(snap_dec % 7'd10);
      2'd1: dig_val = 4'(snap_dec / 7'd10);
      2'd2: dig_val = 4'(snap_int % 7'd10);
      2'd3: dig_val = 4'(snap_int / 7'd10);
    endcase
  end

`ifdef FND_LZB_EN
  assign blank = (idx == 2'd3) && (snap_int < 7'd10);
`else
  assign blank = 1'b0;
`endif
  assign dp = (idx == 2'd2);

  fnd_seg_decoder u_dec (
    .val   (dig_val),
    .blank (blank),
    .dp    (dp),
    .seg   (seg)
  );

  // Scan divider, digit index, registered outputs and frame snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      idx      <= '0;
      fnd_com  <= 4'b1111;
      fnd_data <= SEG_BLANK;
      snap_int <= '0;
      snap_dec <= '0;
      cur_ch   <= '0;
    end else begin
      div_cnt <= scan_tick ? '0 : div_cnt + 1'b1;
      if (scan_tick) begin
        idx      <= idx + 1'b1;
        fnd_com  <= ~(4'b0001 << idx);
        fnd_data <= seg;
      end
      if (frame_end) begin
        snap_int <= sat99(sel_int);
        snap_dec <= sat99(sel_dec);
        cur_ch   <= sel_ch;
      end
    end
  end

  // Seconds counter and rotation; both parked at 0 in manual mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_cnt     <= '0;
      rot_sec_cnt <= '0;
      rot_idx     <= '0;
    end else begin
      rot_idx <= rot_nxt;
      if (!mode_auto) begin
        sec_cnt     <= '0;
        rot_sec_cnt <= '0;
      end else if (sec_tick) begin
        sec_cnt     <= '0;
        rot_sec_cnt <= rot_adv ? '0 : rot_sec_cnt + 1'b1;
      end else begin
        sec_cnt <= sec_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fnd_multi_ch_scanner.sv
module tb_fnd_multi_ch_scanner;
  localparam int NUM_CH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ch_int, ch_dec;
  logic        mode_auto;
  logic [1:0]  ch_sel;
  logic [7:0]  fnd_data;
  logic [3:0]  fnd_com;
  logic [1:0]  cur_ch;

  int n_tests = 0;
  int n_fail  = 0;
  int n;

  fnd_multi_ch_scanner #(
    .CLK_HZ(1000), .SCAN_HZ(100), .NUM_CH(NUM_CH), .ROT_SEC(1)
  ) dut (
    .clk(clk), .rst(rst), .ch_int(ch_int), .ch_dec(ch_dec),
    .mode_auto(mode_auto), .ch_sel(ch_sel),
    .fnd_data(fnd_data), .fnd_com(fnd_com), .cur_ch(cur_ch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for fnd_com to switch to a given digit enable (bounded).
  task automatic wait_com(input logic [3:0] exp, input string tag);
    logic [3:0] old;
    bit hit = 0;
    for (int i = 0; i < 60; i++) begin
      old = fnd_com;
      @(posedge clk); #1;
      if (fnd_com != old && fnd_com == exp) begin hit = 1; break; end
    end
    if (!hit) begin
      n_tests++; n_fail++;
      $error("FAIL %s: timeout waiting for fnd_com %0h, observed %0h", tag, exp, fnd_com);
    end
  endtask

  // Count edges until cur_ch changes (bounded).
  task automatic wait_ch(output int cyc);
    logic [1:0] old = cur_ch;
    cyc = 0;
    for (int i = 0; i < 1200; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (cur_ch != old) return;
    end
    n_tests++; n_fail++;
    $error("FAIL cur_ch_wait: timeout, observed %0h", cur_ch);
  endtask

  // After reset release: blank for 9 clocks, digit 0 of a zero snapshot on the 10th.
  task automatic first_frame(input string tag);
    @(negedge clk) rst = 1'b0;
    repeat (9) @(posedge clk);
    #1 chk({tag, "_com_pre"}, fnd_com, 4'hF);
    @(posedge clk); #1;
    chk({tag, "_com_d0"}, fnd_com, 4'hE);
    chk({tag, "_data_d0"}, fnd_data, 8'hC0);
  endtask

  function automatic logic [7:0] b8(input int v);
    return v[7:0];
  endfunction

  initial begin
    rst = 1'b1; mode_auto = 1'b0; ch_sel = 2'd0;
    ch_int = {b8(5), b8(56), b8(12), b8(23)};
    ch_dec = {b8(0), b8(78), b8(34), b8(45)};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_com", fnd_com, 4'hF);
    chk("rst_data", fnd_data, 8'hFF);
    chk("rst_cur_ch", cur_ch, 2'd0);

    first_frame("start");

    // ch0 = 23.45 loaded at end of the first frame
    wait_com(4'h7, "f1_d3");
    wait_com(4'hE, "f2_d0"); chk("c0_d0", fnd_data, 8'h92);
    wait_com(4'hD, "f2_d1"); chk("c0_d1", fnd_data, 8'h99);
    wait_com(4'hB, "f2_d2"); chk("c0_d2", fnd_data, 8'h30);
    wait_com(4'h7, "f2_d3"); chk("c0_d3", fnd_data, 8'hA4);

    // saturation: 150 -> 99, dec 7 -> 07
    ch_int[7:0] = 8'd150; ch_dec[7:0] = 8'd7;
    wait_com(4'h7, "f3_d3");
    wait_com(4'hE, "sat_e"); chk("sat_d0", fnd_data, 8'hF8);
    wait_com(4'hD, "sat_d"); chk("sat_d1", fnd_data, 8'hC0);
    wait_com(4'hB, "sat_b"); chk("sat_d2", fnd_data, 8'h10);
    wait_com(4'h7, "sat_7"); chk("sat_d3", fnd_data, 8'h90);

    // mid-frame ch_sel change: frame finishes on ch0
    wait_com(4'hE, "ms_e"); chk("ms_d0", fnd_data, 8'hF8);
    ch_sel = 2'd1;
    wait_com(4'hD, "ms_d"); chk("ms_d1", fnd_data, 8'hC0);
    wait_com(4'hB, "ms_b"); chk("ms_d2", fnd_data, 8'h10);
    chk("ms_cur_old", cur_ch, 2'd0);
    wait_com(4'h7, "ms_7"); chk("ms_d3", fnd_data, 8'h90);
    chk("ms_cur_new", cur_ch, 2'd1);
    wait_com(4'hE, "c1_e"); chk("c1_d0", fnd_data, 8'h99);
    wait_com(4'hD, "c1_d"); chk("c1_d1", fnd_data, 8'hB0);
    wait_com(4'hB, "c1_b"); chk("c1_d2", fnd_data, 8'h24);
    wait_com(4'h7, "c1_7"); chk("c1_d3", fnd_data, 8'hF9);

    // leading digit of 05.00
    ch_sel = 2'd3;
    wait_com(4'h7, "c3_load");
    chk("c3_cur", cur_ch, 2'd3);
    wait_com(4'hE, "c3_e"); chk("c3_d0", fnd_data, 8'hC0);
    wait_com(4'hB, "c3_b"); chk("c3_d2", fnd_data, 8'h12);
    wait_com(4'h7, "c3_7");
`ifdef FND_LZB_EN
    chk("lzb_d3", fnd_data, 8'hFF);
`else
    chk("lzb_d3", fnd_data, 8'hC0);
`endif

    // auto rotation enabled right on a frame boundary; the second advance
    // then lands exactly on a boundary
    mode_auto = 1'b1;
    wait_ch(n); chk("auto0_cyc", n, 40);  chk("auto0_ch", cur_ch, 2'd0); chk("auto0_com", fnd_com, 4'h7);
    wait_ch(n); chk("auto1_cyc", n, 960); chk("auto1_ch", cur_ch, 2'd1); chk("auto1_com", fnd_com, 4'h7);
    wait_ch(n); chk("auto2_cyc", n, 1000); chk("auto2_ch", cur_ch, 2'd2);
    wait_ch(n); chk("auto3_cyc", n, 1000); chk("auto3_ch", cur_ch, 2'd3);
    wait_ch(n); chk("auto4_cyc", n, 1000); chk("auto4_ch", cur_ch, 2'd0); chk("auto4_com", fnd_com, 4'h7);

    // back to manual ch2, then reset during digit 2
    mode_auto = 1'b0; ch_sel = 2'd2;
    wait_com(4'h7, "m2_load");
    chk("m2_cur", cur_ch, 2'd2);
    wait_com(4'hB, "rst_b");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_com", fnd_com, 4'hF);
    chk("mid_rst_data", fnd_data, 8'hFF);
    chk("mid_rst_cur", cur_ch, 2'd0);
    first_frame("restart");
    wait_com(4'h7, "r_load");
    chk("r_cur", cur_ch, 2'd2);
    wait_com(4'hE, "r_e"); chk("r_d0", fnd_data, 8'h80);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
